ls_ex: RTL and testbench

Load/store execution unit: the responder on the LSB-to-EX issue interface. It accepts one memory operation per issue (op, address, store value, ROB id), drives a word-level request to the memory controller and waits for completion. For loads it sign- or zero-extends the returned data and broadcasts it on the LS CDB. It is non-pipelined: one operation in flight, and it back-pressures the LSB through busy_to_lsb.

---
 rtl/ls_ex_if.sv | 49 ++++
 rtl/ls_ex.sv | 174 +++++++++++++++++
 tb/tb_ls_ex.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_ex_if.sv
// ls_ex_if: bundles every ls_ex signal except clk, rst and rdy.
//   LSB issue : ena/openum/mem_addr/store_value/rob_id from LSB, busy back
//   MC        : mem_ena/wr/addr/size/wdata out, mem_done/rdata back
//   LS CDB    : valid/rob_id/result out
//   ROB       : rollback flag in
// Modport slave is the load/store unit; modport master is its environment
// (LSB, memory controller, ROB, CDB listeners).
interface ls_ex_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int OPENUM_WIDTH = 6
);
  logic                    ena_from_lsb;
  logic [OPENUM_WIDTH-1:0] openum_from_lsb;
  logic [ADDR_WIDTH-1:0]   mem_addr_from_lsb;
  logic [DATA_WIDTH-1:0]   store_value_from_lsb;
  logic [ROB_ID_WIDTH-1:0] rob_id_from_lsb;
  logic                    busy_to_lsb;
  logic                    mem_ena_to_mc;
  logic                    mem_wr_to_mc;
  logic [ADDR_WIDTH-1:0]   mem_addr_to_mc;
  logic [2:0]              mem_size_to_mc;
  logic [DATA_WIDTH-1:0]   mem_wdata_to_mc;
  logic                    mem_done_from_mc;
  logic [DATA_WIDTH-1:0]   mem_rdata_from_mc;
  logic                    valid_to_cdb;
  logic [ROB_ID_WIDTH-1:0] rob_id_to_cdb;
  logic [DATA_WIDTH-1:0]   result_to_cdb;
  logic                    rollback_flag_from_rob;

  modport slave (
    input  ena_from_lsb, openum_from_lsb, mem_addr_from_lsb,
           store_value_from_lsb, rob_id_from_lsb,
           mem_done_from_mc, mem_rdata_from_mc, rollback_flag_from_rob,
    output busy_to_lsb, mem_ena_to_mc, mem_wr_to_mc, mem_addr_to_mc,
           mem_size_to_mc, mem_wdata_to_mc,
           valid_to_cdb, rob_id_to_cdb, result_to_cdb
  );

  modport master (
    output ena_from_lsb, openum_from_lsb, mem_addr_from_lsb,
           store_value_from_lsb, rob_id_from_lsb,
           mem_done_from_mc, mem_rdata_from_mc, rollback_flag_from_rob,
    input  busy_to_lsb, mem_ena_to_mc, mem_wr_to_mc, mem_addr_to_mc,
           mem_size_to_mc, mem_wdata_to_mc,
           valid_to_cdb, rob_id_to_cdb, result_to_cdb
  );
endinterface

// File: rtl/ls_ex.sv
// ls_ex: non-pipelined load/store execution unit.
// Accepts one memory op from the LSB, issues a word-level request to the
// memory controller, waits for the done pulse and, for loads, broadcasts the
// sign/zero-extended result on the LS CDB for one cycle.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   rdy  - global ready; low freezes every register (mem_done is not sampled)
//   bus  - ls_ex_if.slave: LSB issue, memory controller, LS CDB, ROB rollback
module ls_ex #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int OPENUM_WIDTH = 6
) (
  input logic    clk,
  input logic    rst,
  input logic    rdy,
  ls_ex_if.slave bus
);

  localparam logic [OPENUM_WIDTH-1:0] OPENUM_LB  = OPENUM_WIDTH'(1);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_LH  = OPENUM_WIDTH'(2);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_LW  = OPENUM_WIDTH'(3);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_LBU = OPENUM_WIDTH'(4);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_LHU = OPENUM_WIDTH'(5);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_SB  = OPENUM_WIDTH'(6);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_SH  = OPENUM_WIDTH'(7);
  localparam logic [OPENUM_WIDTH-1:0] OPENUM_SW  = OPENUM_WIDTH'(8);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  function automatic logic is_store_op(input logic [OPENUM_WIDTH-1:0] op);
    return (op == OPENUM_SB) || (op == OPENUM_SH) || (op == OPENUM_SW);
  endfunction

  function automatic logic is_load_op(input logic [OPENUM_WIDTH-1:0] op);
    return (op == OPENUM_LB) || (op == OPENUM_LH) || (op == OPENUM_LW) ||
           (op == OPENUM_LBU) || (op == OPENUM_LHU);
  endfunction

  // Byte count of the access; unknown encodings fall back to a full word.
  function automatic logic [2:0] size_of(input logic [OPENUM_WIDTH-1:0] op);
    case (op)
      OPENUM_LB, OPENUM_LBU, OPENUM_SB: return 3'd1;
      OPENUM_LH, OPENUM_LHU, OPENUM_SH: return 3'd2;
      default:                          return 3'd4;
    endcase
  endfunction

  // The controller returns zero-extended data; only signed loads need work.
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [OPENUM_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]   rdata
  );
    case (op)
      OPENUM_LB:  return {{(DATA_WIDTH-8){rdata[7]}}, rdata[7:0]};
      OPENUM_LH:  return {{(DATA_WIDTH-16){rdata[15]}}, rdata[15:0]};
      OPENUM_LBU: return {{(DATA_WIDTH-8){1'b0}}, rdata[7:0]};
      OPENUM_LHU: return {{(DATA_WIDTH-16){1'b0}}, rdata[15:0]};
      default:    return rdata;
    endcase
  endfunction

  state_t                  state_r, state_s;
  logic                    accept_s, finish_s, broadcast_s;
  logic [OPENUM_WIDTH-1:0] op_r;
  logic [ROB_ID_WIDTH-1:0] rob_r;
  logic                    cancel_r;
  logic                    mem_ena_r, mem_wr_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [2:0]              mem_size_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    valid_r;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_r;
  logic [DATA_WIDTH-1:0]   result_r;

  // FSM state register; rdy low holds the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (rdy) begin
      state_r <= state_s;
    end
  end

  // Next state plus accept / finish / broadcast strobes.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    broadcast_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A rollback in the issue cycle drops the op.
        if (bus.ena_from_lsb && !bus.rollback_flag_from_rob) begin
          accept_s = 1'b1;
          state_s  = WAIT_MEM;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_done_from_mc) begin
          finish_s    = 1'b1;
          state_s     = IDLE;
          // Stores are already committed, so only loads can be cancelled.
          broadcast_s = is_load_op(op_r) && !cancel_r &&
                        !bus.rollback_flag_from_rob;
        end else begin
          state_s = WAIT_MEM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request, cancel and CDB registers; all frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r        <= '0;
      rob_r       <= '0;
      cancel_r    <= 1'b0;
      mem_ena_r   <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_size_r  <= 3'd0;
      mem_wdata_r <= '0;
      valid_r     <= 1'b0;
      cdb_rob_r   <= '0;
      result_r    <= '0;
    end else if (rdy) begin
      valid_r <= broadcast_s;
      if (accept_s) begin
        op_r        <= bus.openum_from_lsb;
        rob_r       <= bus.rob_id_from_lsb;
        cancel_r    <= 1'b0;
        mem_ena_r   <= 1'b1;
        mem_wr_r    <= is_store_op(bus.openum_from_lsb);
        mem_addr_r  <= bus.mem_addr_from_lsb;
        mem_size_r  <= size_of(bus.openum_from_lsb);
        mem_wdata_r <= bus.store_value_from_lsb;
      end else if (finish_s) begin
        // Address/size/data keep their value; only the valid drops.
        mem_ena_r <= 1'b0;
      end else if ((state_r == WAIT_MEM) && bus.rollback_flag_from_rob &&
                   is_load_op(op_r)) begin
        // The request stays on the bus until done; only the result is lost.
        cancel_r <= 1'b1;
      end
      if (broadcast_s) begin
        cdb_rob_r <= rob_r;
        result_r  <= load_ext(op_r, bus.mem_rdata_from_mc);
      end
    end
  end

  assign bus.busy_to_lsb     = (state_r != IDLE) || bus.ena_from_lsb;
  assign bus.mem_ena_to_mc   = mem_ena_r;
  assign bus.mem_wr_to_mc    = mem_wr_r;
  assign bus.mem_addr_to_mc  = mem_addr_r;
  assign bus.mem_size_to_mc  = mem_size_r;
  assign bus.mem_wdata_to_mc = mem_wdata_r;
  // A rollback during the broadcast cycle kills the broadcast.
  assign bus.valid_to_cdb    = valid_r && !bus.rollback_flag_from_rob;
  assign bus.rob_id_to_cdb   = cdb_rob_r;
  assign bus.result_to_cdb   = result_r;

endmodule

// File: tb/tb_ls_ex.sv
// tb_ls_ex: self-checking bench for ls_ex. Directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ls_ex;

  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  ls_ex_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_ID_WIDTH(4), .OPENUM_WIDTH(6)) bus ();

  ls_ex #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_ID_WIDTH(4), .OPENUM_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail < 60) $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_load(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic [2:0] nbytes(input logic [5:0] op);
    if (op inside {LB, LBU, SB}) return 3'd1;
    if (op inside {LH, LHU, SH}) return 3'd2;
    return 3'd4;
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] d);
    if (op == LB)  return int'(byte'(d[7:0]));
    if (op == LH)  return int'(shortint'(d[15:0]));
    if (op == LBU) return d % 32'd256;
    if (op == LHU) return d % 32'd65536;
    return d;
  endfunction

  bit          m_inflight = 1'b0;
  logic [5:0]  m_op = 6'd0;
  logic [3:0]  m_rob = 4'd0;
  bit          m_cancel = 1'b0;
  logic        e_mem_ena = 1'b0;
  logic        e_wr = 1'b0;
  logic [31:0] e_addr = 32'd0;
  logic [2:0]  e_size = 3'd0;
  logic [31:0] e_wdata = 32'd0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_rob = 4'd0;
  logic [31:0] e_result = 32'd0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_inflight = 1'b0; m_op = 6'd0; m_rob = 4'd0; m_cancel = 1'b0;
        e_mem_ena = 1'b0; e_wr = 1'b0; e_addr = 32'd0; e_size = 3'd0; e_wdata = 32'd0;
        e_valid = 1'b0; e_rob = 4'd0; e_result = 32'd0;
      end else if (rdy) begin
        e_valid = 1'b0;
        if (!m_inflight) begin
          if (bus.ena_from_lsb && !bus.rollback_flag_from_rob) begin
            m_inflight = 1'b1;
            m_op = bus.openum_from_lsb;
            m_rob = bus.rob_id_from_lsb;
            m_cancel = 1'b0;
            e_mem_ena = 1'b1;
            e_wr = is_store(m_op);
            e_addr = bus.mem_addr_from_lsb;
            e_size = nbytes(m_op);
            e_wdata = bus.store_value_from_lsb;
          end
        end else begin
          if (bus.rollback_flag_from_rob && is_load(m_op)) m_cancel = 1'b1;
          if (bus.mem_done_from_mc) begin
            m_inflight = 1'b0;
            e_mem_ena = 1'b0;
            if (is_load(m_op) && !m_cancel) begin
              e_valid = 1'b1;
              e_rob = m_rob;
              e_result = extend(m_op, bus.mem_rdata_from_mc);
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("busy",      bus.busy_to_lsb,     m_inflight || bus.ena_from_lsb);
      check("mem_ena",   bus.mem_ena_to_mc,   e_mem_ena);
      check("mem_wr",    bus.mem_wr_to_mc,    e_wr);
      check("mem_addr",  bus.mem_addr_to_mc,  e_addr);
      check("mem_size",  bus.mem_size_to_mc,  e_size);
      check("mem_wdata", bus.mem_wdata_to_mc, e_wdata);
      check("cdb_valid", bus.valid_to_cdb,    e_valid && !bus.rollback_flag_from_rob);
      check("cdb_rob",   bus.rob_id_to_cdb,   e_rob);
      check("cdb_res",   bus.result_to_cdb,   e_result);
    end
  end

  // ---------------- memory controller responder ----------------
  bit          auto_mode = 1'b0;
  bit          man_done = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  int          resp_cnt = 0;

  initial begin
    bus.mem_done_from_mc  = 1'b0;
    bus.mem_rdata_from_mc = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (!auto_mode) begin
        bus.mem_done_from_mc  = man_done;
        bus.mem_rdata_from_mc = man_rdata;
      end else if (!m_inflight) begin
        bus.mem_done_from_mc = 1'b0;
      end else if (!bus.mem_done_from_mc) begin
        if (resp_cnt == 0) begin
          bus.mem_done_from_mc  = 1'b1;
          bus.mem_rdata_from_mc = $urandom;
          resp_cnt = $urandom_range(0, 3);
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] val, input logic [3:0] rob);
    @(negedge clk);
    bus.ena_from_lsb = 1'b1;
    bus.openum_from_lsb = op;
    bus.mem_addr_from_lsb = addr;
    bus.store_value_from_lsb = val;
    bus.rob_id_from_lsb = rob;
    #3 check("busy_on_issue", bus.busy_to_lsb, 1'b1);
    @(negedge clk);
    bus.ena_from_lsb = 1'b0;
  endtask

  // Returns in the cycle right after the edge that samples done.
  task automatic mem_complete(input logic [31:0] rdata, input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    @(negedge clk);
    man_done = 1'b1;
    man_rdata = rdata;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  logic [5:0] ops [8];

  initial begin
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    bus.ena_from_lsb = 1'b0;
    bus.openum_from_lsb = 6'd0;
    bus.mem_addr_from_lsb = 32'd0;
    bus.store_value_from_lsb = 32'd0;
    bus.rob_id_from_lsb = 4'd0;
    bus.rollback_flag_from_rob = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    #3;
    check("rst_busy", bus.busy_to_lsb, 1'b0);
    check("rst_mem_ena", bus.mem_ena_to_mc, 1'b0);
    check("rst_size", bus.mem_size_to_mc, 3'd0);
    check("rst_valid", bus.valid_to_cdb, 1'b0);
    check("rst_result", bus.result_to_cdb, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LB with negative byte
    issue(LB, 32'h100, 32'd0, 4'd3);
    #3;
    check("lb_ena", bus.mem_ena_to_mc, 1'b1);
    check("lb_wr", bus.mem_wr_to_mc, 1'b0);
    check("lb_size", bus.mem_size_to_mc, 3'd1);
    check("lb_addr", bus.mem_addr_to_mc, 32'h100);
    mem_complete(32'h0000_00F0, 2);
    #3;
    check("lb_valid", bus.valid_to_cdb, 1'b1);
    check("lb_rob", bus.rob_id_to_cdb, 4'd3);
    check("lb_result", bus.result_to_cdb, 32'hFFFF_FFF0);
    check("lb_ena_off", bus.mem_ena_to_mc, 1'b0);
    @(negedge clk);
    #3 check("lb_valid_1cyc", bus.valid_to_cdb, 1'b0);

    // LHU then LH with the same data
    issue(LHU, 32'h200, 32'd0, 4'd5);
    #3 check("lhu_size", bus.mem_size_to_mc, 3'd2);
    mem_complete(32'h0000_8001, 1);
    #3 check("lhu_result", bus.result_to_cdb, 32'h0000_8001);
    issue(LH, 32'h200, 32'd0, 4'd6);
    mem_complete(32'h0000_8001, 0);
    #3 check("lh_result", bus.result_to_cdb, 32'hFFFF_8001);
    check("lh_rob", bus.rob_id_to_cdb, 4'd6);

    // SW: write, no broadcast
    issue(SW, 32'h1000, 32'hDEAD_BEEF, 4'd7);
    #3;
    check("sw_wr", bus.mem_wr_to_mc, 1'b1);
    check("sw_size", bus.mem_size_to_mc, 3'd4);
    check("sw_wdata", bus.mem_wdata_to_mc, 32'hDEAD_BEEF);
    mem_complete(32'd0, 2);
    #3;
    check("sw_no_valid", bus.valid_to_cdb, 1'b0);
    check("sw_rob_hold", bus.rob_id_to_cdb, 4'd6);

    // Back-pressure: ena held through the whole transaction
    @(negedge clk);
    bus.ena_from_lsb = 1'b1;
    bus.openum_from_lsb = LW;
    bus.mem_addr_from_lsb = 32'h300;
    bus.rob_id_from_lsb = 4'd8;
    @(negedge clk);
    bus.mem_addr_from_lsb = 32'h400;
    bus.rob_id_from_lsb = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_busy", bus.busy_to_lsb, 1'b1);
      check("bp_addr", bus.mem_addr_to_mc, 32'h300);
      @(negedge clk);
    end
    man_done = 1'b1;
    man_rdata = 32'h1234_5678;
    @(negedge clk);
    man_done = 1'b0;
    #3;
    check("bp_valid", bus.valid_to_cdb, 1'b1);
    check("bp_rob", bus.rob_id_to_cdb, 4'd8);
    check("bp_busy_done", bus.busy_to_lsb, 1'b1);
    @(negedge clk);
    bus.ena_from_lsb = 1'b0;
    #3;
    check("bp_second_ena", bus.mem_ena_to_mc, 1'b1);
    check("bp_second_addr", bus.mem_addr_to_mc, 32'h400);
    mem_complete(32'h0000_0055, 0);
    #3 check("bp_second_rob", bus.rob_id_to_cdb, 4'd9);

    // Rollback during a load wait
    issue(LW, 32'h500, 32'd0, 4'd10);
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b1;
    #3 check("rb_ena_held", bus.mem_ena_to_mc, 1'b1);
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b0;
    mem_complete(32'h1234_5678, 1);
    #3;
    check("rb_no_valid", bus.valid_to_cdb, 1'b0);
    check("rb_ena_off", bus.mem_ena_to_mc, 1'b0);
    issue(SB, 32'h600, 32'h0000_00AB, 4'd11);
    #3 check("rb_next_accept", bus.mem_ena_to_mc, 1'b1);
    mem_complete(32'd0, 0);
    // Rollback together with ena in IDLE drops the issue
    @(negedge clk);
    bus.ena_from_lsb = 1'b1;
    bus.rollback_flag_from_rob = 1'b1;
    @(negedge clk);
    bus.ena_from_lsb = 1'b0;
    bus.rollback_flag_from_rob = 1'b0;
    #3 check("rb_idle_drop", bus.mem_ena_to_mc, 1'b0);

    // rdy low for 4 cycles with done held
    issue(LW, 32'h700, 32'd0, 4'd12);
    @(negedge clk);
    rdy = 1'b0;
    man_done = 1'b1;
    man_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("rdy_ena_held", bus.mem_ena_to_mc, 1'b1);
      check("rdy_no_valid", bus.valid_to_cdb, 1'b0);
    end
    rdy = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    #3;
    check("rdy_valid", bus.valid_to_cdb, 1'b1);
    check("rdy_result", bus.result_to_cdb, 32'hCAFE_F00D);

    // Asynchronous reset mid-wait
    issue(LW, 32'h800, 32'd0, 4'd13);
    @(posedge clk);
    #1 check("arst_before", bus.mem_ena_to_mc, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_ena", bus.mem_ena_to_mc, 1'b0);
    check("arst_busy", bus.busy_to_lsb, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    auto_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 7) != 0);
      bus.rollback_flag_from_rob = ($urandom_range(0, 15) == 0);
      bus.ena_from_lsb = $urandom_range(0, 1);
      bus.openum_from_lsb = ops[$urandom_range(0, 7)];
      bus.mem_addr_from_lsb = $urandom;
      bus.store_value_from_lsb = $urandom;
      bus.rob_id_from_lsb = 4'($urandom_range(1, 15));
    end
    @(negedge clk);
    rdy = 1'b1;
    bus.ena_from_lsb = 1'b0;
    bus.rollback_flag_from_rob = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
